// File: rtl/mad_outlier_flag.sv
// Flags samples whose distance from the latched median exceeds THRESH_K * MAD,
// re-reading the population from sample memory and streaming one flag per sample.
//
// state | meaning
// IDLE  | waiting for a stats_vld pulse
// LATCH | scale MAD by THRESH_K into the threshold
// REQ   | issue one memory read for the current address
// WAIT  | wait for the read data return
// EMIT  | present the flag until the consumer accepts it
// DONE  | one-cycle end-of-pass pulse
module mad_outlier_flag #(
  parameter int          POPSIZE    = 100,
  parameter int          DATA_WIDTH = 8,
  parameter logic [15:0] THRESH_K   = 16'h0300,
  localparam int         AW         = (POPSIZE > 1) ? $clog2(POPSIZE) : 1,
  localparam int         CW         = $clog2(POPSIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stats_vld,
  input  logic [15:0]           local_median,
  input  logic [15:0]           mad,
  output logic                  rd_rqst,
  output logic [AW-1:0]         addr_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_rdy,
  output logic                  flag_vld,
  input  logic                  flag_ready,
  output logic                  flag,
  output logic [AW-1:0]         flag_addr,
  output logic [CW-1:0]         outlier_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [AW-1:0] LAST_ADDR = AW'(POPSIZE - 1);

  logic [2:0]    state;
  logic [15:0]   med_r;
  logic [15:0]   mad_r;
  logic [15:0]   thr;
  logic [AW-1:0] addr;

  logic [31:0] prod;
  logic        prod_sat;
  logic        unused_prod_lsb;
  logic [7:0]  sample8;
  logic [15:0] sample_fx;
  logic [15:0] dev;

  // Full 16x16 product; anything above bit 23 cannot be represented in 8.8.
  assign prod            = {16'h0000, mad_r} * {16'h0000, THRESH_K};
  assign prod_sat        = |prod[31:24];
  assign unused_prod_lsb = ^prod[7:0];

  assign sample8   = 8'(data_in);
  assign sample_fx = {sample8, 8'h00};
  assign dev       = (sample_fx >= med_r) ? (sample_fx - med_r) : (med_r - sample_fx);

  assign rd_rqst = (state == S_REQ);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      med_r       <= '0;
      mad_r       <= '0;
      thr         <= '0;
      addr        <= '0;
      addr_out    <= '0;
      flag        <= 1'b0;
      flag_addr   <= '0;
      flag_vld    <= 1'b0;
      outlier_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (stats_vld) begin
            med_r       <= local_median;
            mad_r       <= mad;
            outlier_cnt <= '0;
            addr        <= '0;
            state       <= S_LATCH;
          end
        end
        S_LATCH: begin
          thr      <= prod_sat ? 16'hFFFF : prod[23:8];
          addr_out <= addr;
          state    <= S_REQ;
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (data_rdy) begin
            flag      <= (dev > thr);
            flag_addr <= addr;
            flag_vld  <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (flag_ready) begin
            flag_vld    <= 1'b0;
            outlier_cnt <= outlier_cnt + CW'(flag);
            if (addr == LAST_ADDR) begin
              state <= S_DONE;
            end else begin
              // addr_out moves only when the next REQ is entered
              addr     <= addr + AW'(1);
              addr_out <= addr + AW'(1);
              state    <= S_REQ;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mad_outlier_flag.sv
// Scoreboard bench for mad_outlier_flag: stimulus queues expected flags and counts,
// a monitor pops and compares on every flag handshake and done pulse.
module tb_mad_outlier_flag;
  localparam int POP = 5;
  localparam int AW  = 3;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stats_vld = 1'b0;
  logic [15:0]   local_median = '0;
  logic [15:0]   mad = '0;
  logic          rd_rqst;
  logic [AW-1:0] addr_out;
  logic [7:0]    data_in = '0;
  logic          data_rdy = 1'b0;
  logic          flag_vld;
  logic          flag_ready = 1'b1;
  logic          flag;
  logic [AW-1:0] flag_addr;
  logic [CW-1:0] outlier_cnt;
  logic          busy;
  logic          done;

  mad_outlier_flag #(.POPSIZE(POP), .DATA_WIDTH(8), .THRESH_K(16'h0300)) dut (
    .clk(clk), .rst(rst), .stats_vld(stats_vld), .local_median(local_median), .mad(mad),
    .rd_rqst(rd_rqst), .addr_out(addr_out), .data_in(data_in), .data_rdy(data_rdy),
    .flag_vld(flag_vld), .flag_ready(flag_ready), .flag(flag), .flag_addr(flag_addr),
    .outlier_cnt(outlier_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int exp_flag_q[$];
  int exp_addr_q[$];
  int exp_cnt_q[$];
  logic [7:0] mem [POP];
  bit rand_dly = 1'b0;
  bit hold_en  = 1'b0;
  int hold_addr = 0;
  int rd_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_rqst"}, rd_rqst, 0);
    check({tag, "_addr_out"}, addr_out, 0);
    check({tag, "_flag_vld"}, flag_vld, 0);
    check({tag, "_flag"}, flag, 0);
    check({tag, "_flag_addr"}, flag_addr, 0);
    check({tag, "_outlier_cnt"}, outlier_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Monitor: samples on the falling edge, inputs change just after rising edges.
  initial begin
    int ef, ea, ec;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (flag_vld && flag_ready) begin
          if (exp_flag_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_flag: got flag %0d addr %0d with nothing expected", flag, flag_addr);
          end else begin
            ef = exp_flag_q.pop_front();
            ea = exp_addr_q.pop_front();
            check("flag", flag, ef);
            check("flag_addr", flag_addr, ea);
          end
        end
        if (rd_rqst) begin
          check("rd_addr", addr_out, rd_cnt);
          rd_cnt++;
        end
        if (done) begin
          if (exp_cnt_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: got done with cnt %0d, none expected", outlier_cnt);
          end else begin
            ec = exp_cnt_q.pop_front();
            check("outlier_cnt", outlier_cnt, ec);
          end
        end
      end
    end
  end

  // Memory model: one response per read, entering WAIT before data_rdy rises.
  initial begin
    int a, d;
    forever begin
      @(posedge clk); #1;
      if (rd_rqst && !rst) begin
        a = int'(addr_out);
        if (!(hold_en && a == hold_addr)) begin
          d = rand_dly ? int'($urandom_range(0, 7)) : 0;
          repeat (d + 1) @(posedge clk);
          #1;
          data_in  = mem[a];
          data_rdy = 1'b1;
          @(posedge clk); #1;
          data_rdy = 1'b0;
        end
      end
    end
  end

  task automatic run_pass(input logic [15:0] med, input logic [15:0] md,
                          input logic [39:0] samples, input logic [4:0] flags,
                          input int n_exp, input int cnt, input int stall_addr,
                          input bit extra, input bit wait_done);
    bit got_done, stalled, bad;
    logic f0;
    logic [AW-1:0] a0;
    for (int i = 0; i < POP; i++) mem[i] = samples[i*8 +: 8];
    for (int i = 0; i < n_exp; i++) begin
      exp_flag_q.push_back(int'(flags[i]));
      exp_addr_q.push_back(i);
    end
    if (cnt >= 0) exp_cnt_q.push_back(cnt);
    rd_cnt = 0;
    @(posedge clk); #1;
    local_median = med; mad = md; stats_vld = 1'b1;
    @(posedge clk); #1;
    stats_vld = 1'b0; local_median = '0; mad = '0;
    if (!wait_done) return;
    got_done = 1'b0;
    stalled  = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      if (extra && c == 6) stats_vld = 1'b1;
      else stats_vld = 1'b0;
      if (stall_addr >= 0 && !stalled && flag_vld && int'(flag_addr) == stall_addr) begin
        flag_ready = 1'b0;
        f0 = flag; a0 = flag_addr; bad = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          if (!flag_vld || flag != f0 || flag_addr != a0 || rd_rqst || !busy) bad = 1'b1;
        end
        check("stall_stable", bad, 0);
        check("stall_flag", f0, flags[stall_addr]);
        flag_ready = 1'b1;
        stalled = 1'b1;
      end
      if (done) got_done = 1'b1;
      @(posedge clk); #1;
    end
    stats_vld = 1'b0;
    check("done_seen", got_done, 1);
    check("rd_count", rd_cnt, POP);
    check("busy_after_done", busy, 0);
    if (cnt >= 0) check("cnt_hold", outlier_cnt, cnt);
    if (stall_addr >= 0) check("stall_done", stalled, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // T1: thr 0x0600, deviations 0,6,7,6,7
    run_pass(16'h3200, 16'h0200, {8'd43, 8'd44, 8'd57, 8'd56, 8'd50}, 5'b10100, 5, 2, -1, 0, 1);
    // T2: saturated threshold
    run_pass(16'h8000, 16'h8000, {8'd200, 8'd1, 8'd128, 8'd255, 8'd0}, 5'b00000, 5, 0, -1, 0, 1);
    // T3: MAD zero flags anything off the median
    run_pass(16'h3200, 16'h0000, {8'd50, 8'd49, 8'd50, 8'd51, 8'd50}, 5'b01010, 5, 2, -1, 0, 1);
    // T4: backpressure on the sample at address 2
    run_pass(16'h3200, 16'h0200, {8'd43, 8'd44, 8'd57, 8'd56, 8'd50}, 5'b10100, 5, 2, 2, 0, 1);
    // T5: random read latency and an ignored stats_vld mid-pass
    rand_dly = 1'b1;
    run_pass(16'h1000, 16'h0100, {8'd12, 8'd13, 8'd19, 8'd20, 8'd16}, 5'b10010, 5, 2, -1, 1, 1);
    rand_dly = 1'b0;

    // T6: reset while waiting for address 3
    hold_en = 1'b1; hold_addr = 3;
    run_pass(16'h3200, 16'h0200, {8'd43, 8'd44, 8'd57, 8'd56, 8'd50}, 5'b10100, 3, -1, -1, 0, 0);
    for (int c = 0; c < 200 && rd_cnt < 4; c++) begin
      @(posedge clk); #1;
    end
    check("abort_reached", rd_cnt, 4);
    repeat (2) @(posedge clk); #1;
    check("abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    hold_en = 1'b0;
    @(negedge clk);
    check_idle("abort_idle");
    check("abort_flags_consumed", exp_flag_q.size(), 0);
    run_pass(16'h3200, 16'h0200, {8'd43, 8'd44, 8'd57, 8'd56, 8'd50}, 5'b10100, 5, 2, -1, 0, 1);

    repeat (4) @(posedge clk); #1;
    check("flag_queue_empty", exp_flag_q.size(), 0);
    check("cnt_queue_empty", exp_cnt_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
